chunked_adder: RTL

CHUNKED_ADDER -- requirements
Module: chunked_adder

---
 rtl/chunked_adder.sv | 136 +++++++++++++
 1 files changed

// File: rtl/chunked_adder.sv
// Chunked ripple adder/subtractor: adds CHUNK bits per cycle over NCH = WIDTH/CHUNK cycles.
// Latency: out_valid rises exactly NCH edges after the accept edge; minimum accept-to-accept spacing is NCH+2.
// Backpressure: the result is held in DONE until out_ready=1; in_ready=1 only in IDLE.
//
// Ports: clk, rst_n (async active-low); in_valid/in_ready handshake with operands a, b, c_in, sub;
//        out_valid/out_ready handshake with result sum, c_out (carry-out, 1 = no borrow in sub mode).
// Optional: define CHUNKED_ADDER_OVF_EN to add output ovf (signed overflow, registered with c_out).
// WIDTH must be an integer multiple of CHUNK.
module chunked_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef CHUNKED_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NCH  = WIDTH / CHUNK;
    localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;      // already inverted for subtraction
    logic [WIDTH-1:0]  sum_q;
    logic              carry;
    logic              c_out_q;
    logic [IDXW-1:0]   idx;
    logic              last;
    logic [CHUNK-1:0]  chunk_a;
    logic [CHUNK-1:0]  chunk_b;
    logic [CHUNK:0]    chunk_res;

    assign last      = (idx == IDXW'(NCH - 1));
    assign chunk_a   = op_a[idx*CHUNK +: CHUNK];
    assign chunk_b   = op_b[idx*CHUNK +: CHUNK];
    assign chunk_res = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK{1'b0}}, carry};

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = sum_q;
    assign c_out     = c_out_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

`ifdef CHUNKED_ADDER_OVF_EN
    logic ovf_q;
    logic msb_cin;

    // On the last chunk, the carry into bit WIDTH-1 is recovered from that bit's sum and operands.
    assign msb_cin = op_a[WIDTH-1] ^ op_b[WIDTH-1] ^ chunk_res[CHUNK-1];
    assign ovf     = ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (state == RUN && last) begin
            ovf_q <= msb_cin ^ chunk_res[CHUNK];
        end
    end
`endif

    // Datapath: operand capture on accept, one chunk per RUN edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a    <= '0;
            op_b    <= '0;
            sum_q   <= '0;
            carry   <= 1'b0;
            c_out_q <= 1'b0;
            idx     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a  <= a;
                        op_b  <= b ^ {WIDTH{sub}};
                        // Subtraction is a + ~b + 1, so c_in is not used then.
                        carry <= sub ? 1'b1 : c_in;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    sum_q[idx*CHUNK +: CHUNK] <= chunk_res[CHUNK-1:0];
                    carry <= chunk_res[CHUNK];
                    if (last) begin
                        idx     <= '0;
                        c_out_q <= chunk_res[CHUNK];
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
